// File: rtl/seg_to_hex_monitor.sv
// Recovers hex digits from an active-low 7-segment bus (bit0=a .. bit6=g) and offers them over valid/ready.
// Optional macro SEG_HISTORY_EN builds the accepted-digit history shift register; otherwise history reads 0.
module seg_to_hex_monitor #(
  parameter int STABLE_CYCLES = 4,
  parameter int DIGITS        = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [6:0]            seg_in,
  input  logic                  clear,
  input  logic                  digit_ready,
  output logic [3:0]            digit_out,
  output logic                  digit_valid,
  output logic                  bad_glyph,
  output logic                  overrun,
  output logic [4*DIGITS-1:0]   history,
  output logic [7:0]            digit_count,
  output logic [1:0]            o_dbg_state
);

  // Handshake: digit_valid rises on accept and holds until an edge with digit_ready=1;
  // the digit is transferred at that edge, and a same-edge accept reloads without overrun.
  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_SETTLE = 2'd1, ST_LOCKED = 2'd2} state_t;

  localparam logic [3:0] CNT_MAX = 4'(STABLE_CYCLES);

  state_t     r_state;
  logic [6:0] r_s_q;
  logic [3:0] r_cnt;

  logic       w_change;
  logic       w_settled;
  logic       w_accept;
  logic       w_bad;
  logic       w_consume;
  logic       w_is_glyph;
  logic       w_is_blank;
  logic [3:0] w_digit;

  assign w_change    = (seg_in != r_s_q);
  assign w_settled   = (r_state == ST_SETTLE) && (r_cnt == CNT_MAX);
  assign w_accept    = w_settled && w_is_glyph && !clear;
  assign w_bad       = w_settled && !w_is_glyph && !w_is_blank && !clear;
  assign w_consume   = digit_valid && digit_ready;
  assign o_dbg_state = r_state;

  always_comb begin
    w_digit    = 4'h0;
    w_is_glyph = 1'b1;
    w_is_blank = 1'b0;
    case (r_s_q)
      7'b1000000: w_digit = 4'h0;
      7'b1111001: w_digit = 4'h1;
      7'b0100100: w_digit = 4'h2;
      7'b0110000: w_digit = 4'h3;
      7'b0011001: w_digit = 4'h4;
      7'b0010010: w_digit = 4'h5;
      7'b0000010: w_digit = 4'h6;
      7'b1111000: w_digit = 4'h7;
      7'b0000000: w_digit = 4'h8;
      7'b0010000: w_digit = 4'h9;
      7'b0001000: w_digit = 4'hA;
      7'b0000011: w_digit = 4'hB;
      7'b1000110: w_digit = 4'hC;
      7'b0100001: w_digit = 4'hD;
      7'b0000110: w_digit = 4'hE;
      7'b0001110: w_digit = 4'hF;
      7'b1111111: begin
        w_is_glyph = 1'b0;
        w_is_blank = 1'b1;
      end
      default:    w_is_glyph = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_s_q       <= 7'b1111111;
      r_cnt       <= 4'd1;
      digit_out   <= 4'h0;
      digit_valid <= 1'b0;
      bad_glyph   <= 1'b0;
      overrun     <= 1'b0;
      digit_count <= 8'd0;
    end else begin
      r_s_q     <= seg_in;
      bad_glyph <= w_bad;
      if (clear) begin
        r_state     <= ST_IDLE;
        r_cnt       <= 4'd1;
        digit_valid <= 1'b0;
        overrun     <= 1'b0;
        digit_count <= 8'd0;
      end else begin
        if (w_change) begin
          r_cnt <= 4'd1;
        end else if (r_cnt != CNT_MAX) begin
          r_cnt <= r_cnt + 4'd1;
        end

        case (r_state)
          ST_IDLE:   if (w_change) r_state <= ST_SETTLE;
          // A change on the deciding edge still gets the settled pattern acted on, then re-settles.
          ST_SETTLE: if (r_cnt == CNT_MAX) r_state <= w_change ? ST_SETTLE : ST_LOCKED;
          ST_LOCKED: if (w_change) r_state <= ST_SETTLE;
          default:   r_state <= ST_IDLE;
        endcase

        if (w_accept) begin
          digit_out   <= w_digit;
          digit_valid <= 1'b1;
          if (digit_valid && !digit_ready) overrun <= 1'b1;
          if (digit_count != 8'hFF) digit_count <= digit_count + 8'd1;
        end else if (w_consume) begin
          digit_valid <= 1'b0;
        end
      end
    end
  end

`ifdef SEG_HISTORY_EN
  logic [4*DIGITS-1:0] r_hist;
  logic [4*DIGITS-1:0] w_digit_ext;

  assign w_digit_ext = (4*DIGITS)'(w_digit);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hist <= '0;
    end else if (clear) begin
      r_hist <= '0;
    end else if (w_accept) begin
      r_hist <= (r_hist << 4) | w_digit_ext;
    end
  end

  assign history = r_hist;
`else
  assign history = '0;
`endif

endmodule

// File: tb/tb_seg_to_hex_monitor.sv
// Self-checking bench for seg_to_hex_monitor: directed segment sequences, a digit scoreboard
// fed by the stimulus and drained by an accept monitor, and a single summary line.
module tb_seg_to_hex_monitor;

  localparam int N      = 4;
  localparam int DIGITS = 4;
`ifdef SEG_HISTORY_EN
  localparam bit HIST_EN = 1'b1;
`else
  localparam bit HIST_EN = 1'b0;
`endif

  logic                clk;
  logic                rst_n;
  logic [6:0]          seg_in;
  logic                clear;
  logic                digit_ready;
  logic [3:0]          digit_out;
  logic                digit_valid;
  logic                bad_glyph;
  logic                overrun;
  logic [4*DIGITS-1:0] history;
  logic [7:0]          digit_count;
  logic [1:0]          o_dbg_state;

  logic [3:0] exp_q[$];
  int         n_cmp;
  int         n_err;
  int         bad_cnt;
  int         prev_count;
  logic       prev_bad;

  seg_to_hex_monitor #(.STABLE_CYCLES(N), .DIGITS(DIGITS)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .seg_in      (seg_in),
    .clear       (clear),
    .digit_ready (digit_ready),
    .digit_out   (digit_out),
    .digit_valid (digit_valid),
    .bad_glyph   (bad_glyph),
    .overrun     (overrun),
    .history     (history),
    .digit_count (digit_count),
    .o_dbg_state (o_dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [31:0] exp_hist(input logic [15:0] v);
    return HIST_EN ? 32'(v) : 32'd0;
  endfunction

  // driver tasks: called just after a rising edge, they leave seg_in held for exactly n samples
  task automatic hold(input logic [6:0] p, input int n);
    seg_in = p;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse_clear();
    clear = 1'b1;
    @(posedge clk);
    #1;
    clear = 1'b0;
  endtask

  // scoreboard monitor: every rise of digit_count is one accept; pop and compare digit_out
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_count = 0;
      prev_bad   = 1'b0;
    end else begin
      if (int'(digit_count) > prev_count) begin
        if (exp_q.size() == 0) begin
          check_eq("sb_queue_size_at_accept", 32'(exp_q.size()), 32'd1);
        end else begin
          check_eq("sb_digit_out", 32'(digit_out), 32'(exp_q.pop_front()));
          check_eq("sb_valid_at_accept", 32'(digit_valid), 32'd1);
        end
      end
      prev_count = int'(digit_count);
      if (bad_glyph) begin
        check_eq("bad_glyph_width", 32'(prev_bad), 32'd0);
        if (!prev_bad) bad_cnt++;
      end
      prev_bad = bad_glyph;
    end
  end

  initial begin
    n_cmp       = 0;
    n_err       = 0;
    bad_cnt     = 0;
    prev_count  = 0;
    prev_bad    = 1'b0;
    rst_n       = 1'b0;
    seg_in      = 7'b1111111;
    clear       = 1'b0;
    digit_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;

    // reset state, blank input: nothing happens
    @(negedge clk);
    check_eq("rst_digit_out", 32'(digit_out), 32'd0);
    check_eq("rst_valid", 32'(digit_valid), 32'd0);
    check_eq("rst_bad", 32'(bad_glyph), 32'd0);
    check_eq("rst_overrun", 32'(overrun), 32'd0);
    check_eq("rst_history", 32'(history), 32'd0);
    check_eq("rst_count", 32'(digit_count), 32'd0);
    check_eq("rst_state", 32'(o_dbg_state), 32'd0);
    @(posedge clk);
    #1;
    hold(7'b1111111, 20);
    check_eq("blank_count", 32'(digit_count), 32'd0);
    check_eq("blank_valid", 32'(digit_valid), 32'd0);

    // digit 2 held 4 samples, consumer not ready
    exp_q.push_back(4'h2);
    hold(7'b0100100, N);
    check_eq("t2_not_early", 32'(digit_valid), 32'd0);
    @(posedge clk);
    #1;
    check_eq("t2_valid", 32'(digit_valid), 32'd1);
    check_eq("t2_digit", 32'(digit_out), 32'h2);
    check_eq("t2_hist", 32'(history[3:0]), exp_hist(16'h0002) & 32'hF);
    check_eq("t2_count", 32'(digit_count), 32'd1);
    digit_ready = 1'b1;
    @(posedge clk);
    #1;
    digit_ready = 1'b0;
    check_eq("t2_consumed", 32'(digit_valid), 32'd0);

    // 7, blank, 7 with ready high: two accepts, then a long hold adds nothing
    pulse_clear();
    check_eq("t3_clear_count", 32'(digit_count), 32'd0);
    digit_ready = 1'b1;
    exp_q.push_back(4'h7);
    hold(7'b1111000, 6);
    hold(7'b1111111, 6);
    exp_q.push_back(4'h7);
    hold(7'b1111000, 6);
    check_eq("t3_count", 32'(digit_count), 32'd2);
    check_eq("t3_hist", 32'(history), exp_hist(16'h0077));
    hold(7'b1111000, 100);
    check_eq("t3_long_count", 32'(digit_count), 32'd2);
    check_eq("t3_valid_consumed", 32'(digit_valid), 32'd0);
    check_eq("t3_state_locked", 32'(o_dbg_state), 32'd2);

    // illegal pattern: one bad_glyph pulse, no accept
    hold(7'b0101010, N);
    check_eq("t4_bad_not_early", 32'(bad_glyph), 32'd0);
    @(posedge clk);
    #1;
    check_eq("t4_bad_high", 32'(bad_glyph), 32'd1);
    @(posedge clk);
    #1;
    check_eq("t4_bad_low", 32'(bad_glyph), 32'd0);
    hold(7'b0101010, 10);
    check_eq("t4_bad_count", 32'(bad_cnt), 32'd1);
    check_eq("t4_valid", 32'(digit_valid), 32'd0);
    check_eq("t4_count", 32'(digit_count), 32'd2);

    // 3 then C without consumer: overrun; clear wipes state
    digit_ready = 1'b0;
    exp_q.push_back(4'h3);
    hold(7'b0110000, 6);
    check_eq("t5_digit3", 32'(digit_out), 32'h3);
    check_eq("t5_no_overrun", 32'(overrun), 32'd0);
    exp_q.push_back(4'hC);
    hold(7'b1000110, 6);
    check_eq("t5_digitC", 32'(digit_out), 32'hC);
    check_eq("t5_overrun", 32'(overrun), 32'd1);
    check_eq("t5_count", 32'(digit_count), 32'd4);
    check_eq("t5_hist", 32'(history), exp_hist(16'h773C));
    pulse_clear();
    check_eq("t5_clr_overrun", 32'(overrun), 32'd0);
    check_eq("t5_clr_hist", 32'(history), 32'd0);
    check_eq("t5_clr_count", 32'(digit_count), 32'd0);
    check_eq("t5_clr_valid", 32'(digit_valid), 32'd0);

    // short 9 then A: only A; a short glitch re-accepts A
    digit_ready = 1'b1;
    exp_q.push_back(4'hA);
    hold(7'b0010000, 2);
    hold(7'b0001000, N);
    @(posedge clk);
    #1;
    check_eq("t6_count", 32'(digit_count), 32'd1);
    check_eq("t6_digit", 32'(digit_out), 32'hA);
    exp_q.push_back(4'hA);
    hold(7'b0000000, 2);
    hold(7'b0001000, 6);
    check_eq("t6_glitch_count", 32'(digit_count), 32'd2);
    check_eq("t6_glitch_hist", 32'(history), exp_hist(16'h00AA));

    // reset mid-settle: the pattern must settle again from scratch
    hold(7'b0110000, 2);
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_eq("t7_rst_count", 32'(digit_count), 32'd0);
    rst_n = 1'b1;
    exp_q.push_back(4'h3);
    repeat (N) @(posedge clk);
    #1;
    check_eq("t7_not_early", 32'(digit_valid), 32'd0);
    @(posedge clk);
    #1;
    check_eq("t7_valid", 32'(digit_valid), 32'd1);
    check_eq("t7_digit", 32'(digit_out), 32'h3);
    check_eq("t7_count", 32'(digit_count), 32'd1);

    repeat (5) @(posedge clk);
    #1;
    check_eq("sb_drain", 32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/seg_to_hex_monitor.md
# seg_to_hex_monitor

Recovers hex digits from a 7-segment drive bus: samples the active-low segment pattern every clock, waits for it to settle, maps it back to a 4-bit digit, and hands each new digit to a consumer over a valid/ready handshake. Used as the inverse of the game's segment drivers, both as an on-chip self-check of the display path and as the bench's display scoreboard. Also keeps a short shift history of accepted digits and flags patterns that are not legal glyphs.

## Interface
- STABLE_CYCLES, 4 — consecutive identical samples needed before a pattern is accepted; legal range 1..15.
- DIGITS, 4 — depth of the accepted-digit history; legal range 1..8.

- clk  in  1  rising-edge system clock.
- rst_n  in  1  asynchronous, active-low reset.
- seg_in  in  7  active-low segments, bit0=a … bit6=g.
- clear  in  1  synchronous clear of handshake, history, counters and FSM.
- digit_ready  in  1  consumer accepts digit_out when high with digit_valid.
- digit_out  out  4  most recently accepted digit.
- digit_valid  out  1  held high from acceptance until consumed.
- bad_glyph  out  1  one-cycle pulse: a settled pattern is neither a glyph nor blank.
- overrun  out  1  sticky: a digit was accepted while the previous one was unconsumed.
- history  out  4*DIGITS  accepted digits, newest in [3:0], older shifted toward MSBs.
- digit_count  out  8  accepted digits since reset/clear, saturates at 255.

## Operation
- Glyph map (seg_in → digit): 1000000→0, 1111001→1, 0100100→2, 0110000→3, 0011001→4, 0010010→5, 0000010→6, 1111000→7, 0000000→8, 0010000→9, 0001000→A, 0000011→b, 1000110→C, 0100001→d, 0000110→E, 0001110→F. 1111111 = blank. Everything else is illegal.
- seg_in is registered (s_q) every edge; the settle counter restarts at 1 when the new sample differs from s_q, otherwise increments, saturating at STABLE_CYCLES.
- FSM states:
  - IDLE: reset state. Counter running; any sample change → SETTLE.
  - SETTLE: on the count reaching STABLE_CYCLES, classify s_q. Glyph → accept. Illegal → pulse bad_glyph. Blank → no event. Then → LOCKED.
  - LOCKED: the pattern is acted on once only. Any sample change → SETTLE.
- Accept: digit_out ← digit; digit_valid ← 1; history ← {history[4*DIGITS-5:0], digit}; digit_count +1 (saturating).
- Handshake: the consumer takes a digit at the edge where digit_valid & digit_ready.
  - Consume with no accept at that edge: digit_valid → 0.
  - Accept and consume at the same edge: the new digit loads, digit_valid stays 1, no overrun.
  - Accept while digit_valid=1 and digit_ready=0: digit_out is overwritten and overrun is set.
- clear, at an edge: digit_valid, overrun, history and digit_count go to 0, and the FSM goes to IDLE with the counter at 1. clear takes priority over a simultaneous accept, which is dropped. s_q keeps sampling.
- Reset values: digit_out=0, digit_valid=0, bad_glyph=0, overrun=0, history=0, digit_count=0, s_q=1111111, FSM=IDLE.
- rst_n low mid-settle aborts the pattern. After release, the current seg_in must settle again from scratch.

## Timing
- Pattern P first sampled at edge e1 and held through edge eN (N=STABLE_CYCLES): digit_valid, digit_out, history and digit_count update at edge eN+1.
- bad_glyph is high for exactly the cycle following edge eN+1.
- A glitch shorter than N samples produces no event. The FSM returns to SETTLE and re-evaluates the original pattern, which is accepted again. This is intended: a glitch is treated as a redraw.
- digit_valid deasserts at the first edge with digit_ready=1; zero-cycle minimum hold.
- All outputs are registered. There are no combinational paths from inputs to outputs.

## Configuration
- SEG_HISTORY_EN defined: the history shift register is built as described.
- SEG_HISTORY_EN undefined: no history storage is built, and history is tied to 0. All other behaviour is unchanged.

## Test plan
- Reset, seg_in=1111111 → all outputs 0; no event for 20 cycles.
- seg_in=0100100 held 4 cycles, digit_ready=0 → digit_valid=1 at edge e5, digit_out=2, history[3:0]=2, digit_count=1. Then digit_ready=1 for 1 cycle → digit_valid=0.
- Sequence 7, blank, 7, each held 6 cycles, digit_ready=1 → exactly two accepts, history[7:0]=0x77, digit_count=2. Holding 7 for 100 cycles → no further accept.
- seg_in=0101010 held 4 cycles → bad_glyph pulses once. digit_valid and digit_count are unchanged.
- Accept 3, then accept C with digit_ready=0 → digit_out=C, overrun=1. Then clear → overrun=0, history=0, digit_count=0.
- 9 held 2 cycles then A held 4 (STABLE_CYCLES=4) → only A accepted. rst_n pulsed low mid-settle → no accept until the pattern has been stable for 4 new samples.
